// File: rtl/spi_flash_slave.sv
// SPI mode-0 flash responder (M25P16 command subset) backed by an on-chip byte RAM.
// SPI pins are oversampled on clk; program/erase timing runs from a separate busy engine.
module spi_flash_slave #(
  parameter int         ADDR_W      = 8,
  parameter int         PROG_CYCLES = 64,
  parameter logic [7:0] ID0         = 8'h20,
  parameter logic [7:0] ID1         = 8'h20,
  parameter logic [7:0] ID2         = 8'h15
) (
  input  logic clk,
  input  logic reset_n,
  input  logic dclk,
  input  logic ncs,
  input  logic w_pin,
  output logic r_pin,
  output logic wip,
  output logic wel
);
  localparam int DEPTH = 2**ADDR_W;
  localparam int PW    = $clog2(PROG_CYCLES + 1);
  localparam int CW    = (PW > ADDR_W) ? PW : ADDR_W;
  localparam logic [ADDR_W-1:0] PAGE_MASK = ADDR_W'(255);

  typedef enum logic [3:0] {IDLE, CMD, ADDR, RDATA, PDATA, STAT, ID, IGNORE, BUSY} state_t;

  state_t            state_q, state_d;
  logic [2:0]        dclk_s_q, dclk_s_d, ncs_s_q, ncs_s_d;
  logic [1:0]        w_s_q, w_s_d;
  logic [5:0]        bit_cnt_q, bit_cnt_d;
  logic [7:0]        sr_q, sr_d, tx_q, tx_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic              r_pin_q, r_pin_d, wel_q, wel_d, wip_q, wip_d;
  logic              erase_q, erase_d, pp_any_q, pp_any_d;
  logic [1:0]        id_idx_q, id_idx_d;
  logic [CW-1:0]     busy_cnt_q, busy_cnt_d;

  logic [7:0]        mem [DEPTH];
  logic [7:0]        rd_data_q;
  logic              mem_we, mem_re;
  logic [ADDR_W-1:0] mem_waddr, mem_raddr;
  logic [7:0]        mem_wdata;

  logic              dclk_rise, dclk_fall, ncs_rise, ncs_fall, w_bit;
  logic [7:0]        din, ld_byte;
  logic [ADDR_W-1:0] addr_in, page_next;

  assign dclk_s_d  = {dclk_s_q[1:0], dclk};
  assign ncs_s_d   = {ncs_s_q[1:0], ncs};
  assign w_s_d     = {w_s_q[0], w_pin};
  assign dclk_rise = dclk_s_q[1] & ~dclk_s_q[2];
  assign dclk_fall = ~dclk_s_q[1] & dclk_s_q[2];
  assign ncs_rise  = ncs_s_q[1] & ~ncs_s_q[2];
  assign ncs_fall  = ~ncs_s_q[1] & ncs_s_q[2];
  assign w_bit     = w_s_q[1];
  assign din       = {sr_q[6:0], w_bit};
  assign addr_in   = {addr_q[ADDR_W-2:0], w_bit};
  // Page program wraps the low 8 address bits only.
  assign page_next = (addr_q & ~PAGE_MASK) | ((addr_q + ADDR_W'(1)) & PAGE_MASK);

  assign r_pin = r_pin_q;
  assign wip   = wip_q;
  assign wel   = wel_q;

  always_comb begin
    ld_byte = rd_data_q;
    if (state_q == STAT) ld_byte = {6'b0, wel_q, wip_q};
    else if (state_q == ID) begin
      case (id_idx_q)
        2'd0:    ld_byte = ID0;
        2'd1:    ld_byte = ID1;
        default: ld_byte = ID2;
      endcase
    end
  end

  always_comb begin
    state_d    = state_q;
    bit_cnt_d  = bit_cnt_q;
    sr_d       = sr_q;
    tx_d       = tx_q;
    addr_d     = addr_q;
    r_pin_d    = r_pin_q;
    wel_d      = wel_q;
    wip_d      = wip_q;
    erase_d    = erase_q;
    pp_any_d   = pp_any_q;
    id_idx_d   = id_idx_q;
    busy_cnt_d = busy_cnt_q;
    mem_we     = 1'b0;
    mem_waddr  = addr_q;
    mem_wdata  = rd_data_q & din;
    mem_re     = 1'b0;
    mem_raddr  = addr_q;

    if (state_q == BUSY && !wip_q) state_d = IDLE;

    if (ncs_rise) begin
      r_pin_d = 1'b0;
      if (state_q == CMD && bit_cnt_q == 6'd8) begin
        case (sr_q)
          8'h06: wel_d = 1'b1;
          8'h04: wel_d = 1'b0;
          8'hC7: if (wel_q) begin
            wel_d = 1'b0; wip_d = 1'b1; erase_d = 1'b1; busy_cnt_d = '0;
          end
          default: ;
        endcase
      end
      if (state_q == PDATA && pp_any_q) begin
        wel_d = 1'b0; wip_d = 1'b1; erase_d = 1'b0; busy_cnt_d = CW'(PROG_CYCLES);
      end
      state_d = wip_d ? BUSY : IDLE;
    end else if (ncs_fall) begin
      state_d   = CMD;
      bit_cnt_d = '0;
      sr_d      = '0;
      tx_d      = '0;
      r_pin_d   = 1'b0;
      pp_any_d  = 1'b0;
      id_idx_d  = '0;
    end else begin
      if (dclk_rise) begin
        case (state_q)
          CMD: begin
            if (bit_cnt_q == 6'd8) state_d = IGNORE;
            else begin
              sr_d      = din;
              bit_cnt_d = bit_cnt_q + 6'd1;
              if (bit_cnt_q == 6'd7) begin
                if (wip_q && din != 8'h05) state_d = IGNORE;
                else begin
                  case (din)
                    8'h06, 8'h04, 8'hC7: state_d = CMD;
                    8'h05:   begin state_d = STAT; bit_cnt_d = '0; end
                    8'h9F:   begin state_d = ID;   bit_cnt_d = '0; end
                    8'h03:   state_d = ADDR;
                    8'h02:   state_d = wel_q ? ADDR : IGNORE;
                    default: state_d = IGNORE;
                  endcase
                end
              end
            end
          end
          ADDR: begin
            addr_d    = addr_in;
            bit_cnt_d = bit_cnt_q + 6'd1;
            if (bit_cnt_q == 6'd31) begin
              // Prefetch: READ needs the byte for the next fall, PP needs it for the AND-merge.
              bit_cnt_d = '0;
              mem_re    = 1'b1;
              mem_raddr = addr_in;
              state_d   = (sr_q == 8'h02) ? PDATA : RDATA;
            end
          end
          RDATA, STAT, ID: begin
            bit_cnt_d = {3'b0, bit_cnt_q[2:0] + 3'd1};
            if (state_q == RDATA && bit_cnt_q[2:0] == 3'd7) begin
              addr_d    = addr_q + ADDR_W'(1);
              mem_re    = 1'b1;
              mem_raddr = addr_q + ADDR_W'(1);
            end
          end
          PDATA: begin
            sr_d      = din;
            bit_cnt_d = {3'b0, bit_cnt_q[2:0] + 3'd1};
            if (bit_cnt_q[2:0] == 3'd7) begin
              mem_we    = 1'b1;
              pp_any_d  = 1'b1;
              addr_d    = page_next;
              mem_re    = 1'b1;
              mem_raddr = page_next;
            end
          end
          default: ;
        endcase
      end
      if (dclk_fall && (state_q == RDATA || state_q == STAT || state_q == ID)) begin
        if (bit_cnt_q[2:0] == 3'd0) begin
          r_pin_d = ld_byte[7];
          tx_d    = {ld_byte[6:0], 1'b0};
          if (state_q == ID) id_idx_d = (id_idx_q == 2'd2) ? 2'd0 : id_idx_q + 2'd1;
        end else begin
          r_pin_d = tx_q[7];
          tx_d    = {tx_q[6:0], 1'b0};
        end
      end
    end

    // Busy engine: erase sweeps one address per clk, program just counts down.
    if (wip_q) begin
      if (erase_q) begin
        mem_we     = 1'b1;
        mem_waddr  = busy_cnt_q[ADDR_W-1:0];
        mem_wdata  = 8'hFF;
        busy_cnt_d = busy_cnt_q + CW'(1);
        if (busy_cnt_q[ADDR_W-1:0] == {ADDR_W{1'b1}}) begin
          wip_d = 1'b0; erase_d = 1'b0; busy_cnt_d = '0;
        end
      end else begin
        busy_cnt_d = busy_cnt_q - CW'(1);
        if (busy_cnt_q == CW'(1)) wip_d = 1'b0;
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q    <= IDLE;
      dclk_s_q   <= '0;
      ncs_s_q    <= '1;
      w_s_q      <= '0;
      bit_cnt_q  <= '0;
      sr_q       <= '0;
      tx_q       <= '0;
      addr_q     <= '0;
      r_pin_q    <= 1'b0;
      wel_q      <= 1'b0;
      wip_q      <= 1'b0;
      erase_q    <= 1'b0;
      pp_any_q   <= 1'b0;
      id_idx_q   <= '0;
      busy_cnt_q <= '0;
    end else begin
      state_q    <= state_d;
      dclk_s_q   <= dclk_s_d;
      ncs_s_q    <= ncs_s_d;
      w_s_q      <= w_s_d;
      bit_cnt_q  <= bit_cnt_d;
      sr_q       <= sr_d;
      tx_q       <= tx_d;
      addr_q     <= addr_d;
      r_pin_q    <= r_pin_d;
      wel_q      <= wel_d;
      wip_q      <= wip_d;
      erase_q    <= erase_d;
      pp_any_q   <= pp_any_d;
      id_idx_q   <= id_idx_d;
      busy_cnt_q <= busy_cnt_d;
    end
  end

  always_ff @(posedge clk) begin
    if (mem_we) mem[mem_waddr] <= mem_wdata;
    if (mem_re) rd_data_q <= mem[mem_raddr];
  end
endmodule

// File: tb/tb_spi_flash_slave.sv
// Bench for spi_flash_slave: a bit-banged SPI master queues expected read bytes,
// a monitor pairs them with the bytes actually shifted back from r_pin.
module tb_spi_flash_slave;
  localparam int HALF = 80;

  logic clk = 1'b0, reset_n = 1'b0, dclk = 1'b0, ncs = 1'b1, w_pin = 1'b0;
  logic r_pin, wip, wel;

  spi_flash_slave #(.ADDR_W(8), .PROG_CYCLES(64)) dut (
    .clk(clk), .reset_n(reset_n), .dclk(dclk), .ncs(ncs),
    .w_pin(w_pin), .r_pin(r_pin), .wip(wip), .wel(wel)
  );

  always #5 clk = ~clk;

  typedef struct { logic [7:0] val; string name; } exp_t;
  exp_t       exp_q[$];
  logic [7:0] got_q[$];
  int checks = 0, errors = 0, wip_cnt = 0;

  always @(negedge clk) if (wip === 1'b1) wip_cnt++;

  task automatic chk1(input string name, input logic act, input logic exp);
    checks++;
    if (act !== exp) begin errors++; $display("FAIL %s got %b expected %b", name, act, exp); end
  endtask

  task automatic chk_range(input string name, input int act, input int lo, input int hi);
    checks++;
    if (act < lo || act > hi) begin errors++; $display("FAIL %s got %0d expected %0d..%0d", name, act, lo, hi); end
  endtask

  task automatic bit_xfer(input logic b, output logic r);
    w_pin = b; #HALF; r = r_pin; dclk = 1'b1; #HALF; dclk = 1'b0;
  endtask

  task automatic send(input logic [7:0] b);
    logic r;
    for (int i = 7; i >= 0; i--) bit_xfer(b[i], r);
  endtask

  task automatic recv(input string name, input logic [7:0] e);
    logic [7:0] rx;
    exp_t x;
    x.val = e; x.name = name;
    exp_q.push_back(x);
    for (int i = 7; i >= 0; i--) bit_xfer(1'b0, rx[i]);
    got_q.push_back(rx);
  endtask

  task automatic cs_lo(); ncs = 1'b0; endtask
  task automatic cs_hi(); #HALF; ncs = 1'b1; #HALF; endtask
  task automatic cmd1(input logic [7:0] op); cs_lo(); send(op); cs_hi(); endtask
  task automatic addr3(input logic [7:0] op, input logic [7:0] a);
    cs_lo(); send(op); send(8'h00); send(8'h00); send(a);
  endtask

  task automatic wait_wip_low(input string name);
    int n = 0;
    while (wip !== 1'b0 && n < 3000) begin @(negedge clk); n++; end
    checks++;
    if (wip !== 1'b0) begin errors++; $display("FAIL %s wip still high after %0d clk", name, n); end
  endtask

  // Scoreboard monitor
  initial begin
    logic [7:0] g;
    exp_t x;
    forever begin
      @(negedge clk);
      while (got_q.size() > 0) begin
        g = got_q.pop_front();
        checks++;
        if (exp_q.size() == 0) begin
          errors++; $display("FAIL unexpected_byte got %h expected none", g);
        end else begin
          x = exp_q.pop_front();
          if (g !== x.val) begin errors++; $display("FAIL %s got %h expected %h", x.name, g, x.val); end
        end
      end
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL timeout got running expected finished");
    $display("CHECKS %0d ERRORS %0d", checks, errors + 1);
    $fatal(1, "timeout");
  end

  initial begin
    logic rb;
    #23 reset_n = 1'b1;
    repeat (5) @(negedge clk);
    chk1("rst_r_pin", r_pin, 1'b0);
    chk1("rst_wip", wip, 1'b0);
    chk1("rst_wel", wel, 1'b0);

    // RDID, including wrap back to ID0
    cs_lo(); send(8'h9F);
    recv("rdid0", 8'h20); recv("rdid1", 8'h20); recv("rdid2", 8'h15); recv("rdid3", 8'h20);
    cs_hi();

    // Reset mid-transaction while r_pin is driving a 1 and wel is set
    cmd1(8'h06);
    chk1("wren_wel", wel, 1'b1);
    cs_lo(); send(8'h9F); bit_xfer(1'b0, rb); bit_xfer(1'b0, rb); #HALF;
    chk1("rdid_bit5", r_pin, 1'b1);
    reset_n = 1'b0; #1;
    chk1("midrst_r_pin", r_pin, 1'b0);
    chk1("midrst_wel", wel, 1'b0);
    chk1("midrst_wip", wip, 1'b0);
    ncs = 1'b1; dclk = 1'b0; #20 reset_n = 1'b1; #HALF;

    // Bulk erase, then a second erase with RDSR during busy
    cmd1(8'h06);
    wip_cnt = 0;
    cmd1(8'hC7);
    wait_wip_low("be1_done");
    chk_range("be1_wip_clk", wip_cnt, 254, 258);
    chk1("be1_wel", wel, 1'b0);
    cmd1(8'h06); cmd1(8'hC7);
    #600;
    cs_lo(); send(8'h05); recv("rdsr_busy", 8'h01); recv("rdsr_live", 8'h00); cs_hi();
    wait_wip_low("be2_done");
    addr3(8'h03, 8'hFE);
    recv("erase_fe", 8'hFF); recv("erase_ff", 8'hFF); recv("erase_00", 8'hFF); recv("erase_01", 8'hFF);
    cs_hi();

    // Write enable status, page program, readback
    cmd1(8'h06);
    cs_lo(); send(8'h05); recv("rdsr_wel", 8'h02); recv("rdsr_wel_rep", 8'h02); cs_hi();
    wip_cnt = 0;
    addr3(8'h02, 8'h10); send(8'hA5); send(8'h5A); cs_hi();
    wait_wip_low("pp_done");
    chk_range("pp_wip_clk", wip_cnt, 62, 66);
    cs_lo(); send(8'h05); recv("rdsr_after_pp", 8'h00); cs_hi();
    addr3(8'h03, 8'h10); recv("read_10", 8'hA5); recv("read_11", 8'h5A); recv("read_12", 8'hFF); cs_hi();

    // Page wrap on program, address wrap on read
    cmd1(8'h06);
    addr3(8'h02, 8'hFE); send(8'h11); send(8'h22); send(8'h33); cs_hi();
    wait_wip_low("ppwrap_done");
    addr3(8'h03, 8'hFE);
    recv("wrap_fe", 8'h11); recv("wrap_ff", 8'h22); recv("wrap_00", 8'h33); recv("wrap_01", 8'hFF);
    cs_hi();

    // Protection and WRDI
    cmd1(8'h06); cmd1(8'h04);
    chk1("wrdi_wel", wel, 1'b0);
    addr3(8'h02, 8'h20); send(8'h00); cs_hi();
    repeat (20) @(negedge clk);
    chk1("pp_nowren_wip", wip, 1'b0);
    addr3(8'h03, 8'h20); recv("prot_20", 8'hFF); cs_hi();
    cmd1(8'hC7);
    repeat (20) @(negedge clk);
    chk1("be_nowren_wip", wip, 1'b0);
    cmd1(8'h06);
    cs_lo(); send(8'hC7); bit_xfer(1'b0, rb); cs_hi();
    repeat (20) @(negedge clk);
    chk1("be_extra_wip", wip, 1'b0);
    chk1("be_extra_wel", wel, 1'b1);

    // Partial byte discarded at ncs rise (wel still set from above)
    wip_cnt = 0;
    addr3(8'h02, 8'h30); send(8'h0F);
    for (int i = 0; i < 5; i++) bit_xfer(1'b0, rb);
    cs_hi();
    wait_wip_low("abort_done");
    chk_range("abort_wip_clk", wip_cnt, 62, 66);
    addr3(8'h03, 8'h30); recv("abort_30", 8'h0F); recv("abort_31", 8'hFF); cs_hi();

    // ncs rise coincident with the 8th data rise: bit not counted
    cmd1(8'h06);
    addr3(8'h02, 8'h40);
    for (int i = 0; i < 7; i++) bit_xfer(1'b0, rb);
    w_pin = 1'b0; #HALF;
    dclk = 1'b1; ncs = 1'b1; #HALF; dclk = 1'b0; #HALF;
    repeat (20) @(negedge clk);
    chk1("collide_wip", wip, 1'b0);
    chk1("collide_wel", wel, 1'b1);
    addr3(8'h03, 8'h40); recv("collide_40", 8'hFF); cs_hi();

    repeat (20) @(negedge clk);
    checks++;
    if (exp_q.size() != 0) begin
      errors++; $display("FAIL leftover_expected got %0d expected 0", exp_q.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
